// File: rtl/vmx_pe_simd_pipe.sv
// Weight-stationary systolic PE with double-buffered weights and a two-stage MAC pipeline.
// In SIMD mode each lane computes its own MAC with no carry into neighbouring lanes.
module vmx_pe_simd_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned SUM_W  = 2 * DATA_W,
  parameter int unsigned LDC_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic              simd_mode_i,
  input  logic [LDC_W-1:0]  load_ctrl_i,
  input  logic              swap_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [SUM_W-1:0]  sum_in_i,
  output logic              valid_pass_o,
  output logic              simd_mode_pass_o,
  output logic [LDC_W-1:0]  load_ctrl_pass_o,
  output logic              swap_pass_o,
  output logic [DATA_W-1:0] data_pass_o,
  output logic              out_valid_o,
  output logic [SUM_W-1:0]  sum_out_o
);

  localparam int unsigned LANES = DATA_W / LANE_W;
  localparam int unsigned PW    = 2 * LANE_W;

  logic [DATA_W-1:0] active_q, shadow_q;
  logic              valid_pass_q, mode_pass_q, swap_pass_q;
  logic [DATA_W-1:0] data_pass_q;
  logic [LDC_W-1:0]  ldc_pass_q, ldc_pass_d;

  logic              v1_q, mode1_q;
  logic [SUM_W-1:0]  prod_q, sum_in_q, prod_d;
  logic              out_valid_q;
  logic [SUM_W-1:0]  sum_q, sum_d;

  logic [LDC_W-2:0]  hops, hops_dec;
  logic              tok_flag, capture;
  logic [SUM_W-1:0]  full_prod, lane_prod;

  assign hops     = load_ctrl_i[LDC_W-2:0];
  assign hops_dec = hops - (LDC_W-1)'(1);
  assign tok_flag = load_ctrl_i[LDC_W-1];
  // The token is consumed by the PE whose countdown has reached zero.
  assign capture  = in_valid_i && tok_flag && (hops == '0);

  always_comb begin
    ldc_pass_d = '0;
    if (in_valid_i && tok_flag && (hops != '0)) begin
      ldc_pass_d = {1'b1, hops_dec};
    end
  end

  always_comb begin
    full_prod = SUM_W'(data_i) * SUM_W'(active_q);
    lane_prod = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_prod[i*PW +: PW] = PW'(data_i[i*LANE_W +: LANE_W]) * PW'(active_q[i*LANE_W +: LANE_W]);
    end
    prod_d = simd_mode_i ? lane_prod : full_prod;
  end

  always_comb begin
    sum_d = '0;
    if (mode1_q) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        sum_d[i*PW +: PW] = prod_q[i*PW +: PW] + sum_in_q[i*PW +: PW];
      end
    end else begin
      sum_d = prod_q + sum_in_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q     <= '0;
      shadow_q     <= '0;
      valid_pass_q <= 1'b0;
      mode_pass_q  <= 1'b0;
      swap_pass_q  <= 1'b0;
      data_pass_q  <= '0;
      ldc_pass_q   <= '0;
      v1_q         <= 1'b0;
      mode1_q      <= 1'b0;
      prod_q       <= '0;
      sum_in_q     <= '0;
      out_valid_q  <= 1'b0;
      sum_q        <= '0;
    end else begin
      valid_pass_q <= in_valid_i;
      mode_pass_q  <= simd_mode_i;
      swap_pass_q  <= swap_i;
      data_pass_q  <= data_i;
      ldc_pass_q   <= ldc_pass_d;
      // Swap promotes the pre-edge shadow, so a coincident capture lands behind it.
      if (swap_i) begin
        active_q <= shadow_q;
      end
      if (capture) begin
        shadow_q <= data_i;
      end
      v1_q        <= in_valid_i;
      mode1_q     <= simd_mode_i;
      prod_q      <= prod_d;
      sum_in_q    <= sum_in_i;
      out_valid_q <= v1_q;
      if (v1_q) begin
        sum_q <= sum_d;
      end
    end
  end

  assign valid_pass_o     = valid_pass_q;
  assign simd_mode_pass_o = mode_pass_q;
  assign load_ctrl_pass_o = ldc_pass_q;
  assign swap_pass_o      = swap_pass_q;
  assign data_pass_o      = data_pass_q;
  assign out_valid_o      = out_valid_q;
  assign sum_out_o        = sum_q;

endmodule

// File: tb/tb_vmx_pe_simd_pipe.sv
// Directed scoreboard bench for vmx_pe_simd_pipe: expected sums are queued at issue and
// popped by an independent monitor whenever out_valid is seen.
module tb_vmx_pe_simd_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid, simd_mode, swap;
  logic [7:0]  load_ctrl;
  logic [15:0] data;
  logic [31:0] sum_in;
  logic        valid_pass, simd_mode_pass, swap_pass, out_valid;
  logic [7:0]  load_ctrl_pass;
  logic [15:0] data_pass;
  logic [31:0] sum_out;

  vmx_pe_simd_pipe dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_valid_i       (in_valid),
    .simd_mode_i      (simd_mode),
    .load_ctrl_i      (load_ctrl),
    .swap_i           (swap),
    .data_i           (data),
    .sum_in_i         (sum_in),
    .valid_pass_o     (valid_pass),
    .simd_mode_pass_o (simd_mode_pass),
    .load_ctrl_pass_o (load_ctrl_pass),
    .swap_pass_o      (swap_pass),
    .data_pass_o      (data_pass),
    .out_valid_o      (out_valid),
    .sum_out_o        (sum_out)
  );

  typedef struct {
    logic [31:0] sum;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [18:0] exp_fwd = '0;
  logic [7:0]  exp_ldc = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every result must match the oldest queued beat and arrive exactly 2 cycles later.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid: sum_out=%h at cycle %0d, no result required", sum_out,
                 cyc);
      end else begin
        mon_e = sb.pop_front();
        if (sum_out !== mon_e.sum || cyc != mon_e.cyc + 2) begin
          n_fail++;
          $display("FAIL sum_out: got %h at cycle %0d, required %h at cycle %0d", sum_out, cyc,
                   mon_e.sum, mon_e.cyc + 2);
        end
      end
    end
  end

  task automatic check_fwd();
    n_cmp++;
    if ({valid_pass, simd_mode_pass, swap_pass, data_pass} !== exp_fwd) begin
      n_fail++;
      $display("FAIL forward: got v=%b m=%b s=%b d=%h, required v=%b m=%b s=%b d=%h",
               valid_pass, simd_mode_pass, swap_pass, data_pass,
               exp_fwd[18], exp_fwd[17], exp_fwd[16], exp_fwd[15:0]);
    end
    n_cmp++;
    if (load_ctrl_pass !== exp_ldc) begin
      n_fail++;
      $display("FAIL load_ctrl_pass: got %h, required %h", load_ctrl_pass, exp_ldc);
    end
  endtask

  // Apply one beat; trk=0 issues it without expecting a result (it is discarded by reset).
  task automatic step(input logic v, input logic m, input logic [7:0] ldc, input logic sw,
                      input logic [15:0] d, input logic [31:0] s, input logic [31:0] e,
                      input logic [7:0] p, input bit trk);
    exp_t x;
    @(posedge clk);
    #1;
    check_fwd();
    in_valid  = v;
    simd_mode = m;
    load_ctrl = ldc;
    swap      = sw;
    data      = d;
    sum_in    = s;
    if (v && trk) begin
      x.sum = e;
      x.cyc = cyc;
      sb.push_back(x);
    end
    exp_fwd = {v, m, sw, d};
    exp_ldc = p;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; simd_mode = 1'b0; swap = 1'b0;
    load_ctrl = '0; data = '0; sum_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, sum_out, valid_pass, load_ctrl_pass, data_pass} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov=%b sum=%h vp=%b ldc=%h dp=%h, required all zero",
               out_valid, sum_out, valid_pass, load_ctrl_pass, data_pass);
    end
    #3 rst = 1'b0;

    //   v  m  ldc    sw d         sum_in         expected sum   ldc_pass
    // Full mode: capture 0x1234, swap it in, then 3*0x1234+5.
    step(1, 0, 8'h80, 0, 16'h1234, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(0, 0, 8'h00, 1, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(1, 0, 8'h00, 0, 16'h0003, 32'h0000_0005, 32'h0000_36A1, 8'h00, 1);
    // SIMD mode against 0x1234 while capturing 0x0203, then against 0x0203.
    step(1, 1, 8'h80, 0, 16'h0203, 32'h0000_0000, 32'h0024_009C, 8'h00, 1);
    step(0, 0, 8'h00, 1, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(1, 1, 8'h00, 0, 16'hFF10, 32'h0001_0002, 32'h01FF_0032, 8'h00, 1);
    // Swap with coincident capture: product still uses 0x0203.
    step(1, 0, 8'h80, 1, 16'hFFFF, 32'h0000_0000, 32'h0202_FDFD, 8'h00, 1);
    step(0, 0, 8'h00, 1, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    // Wrap, back-to-back mode change.
    step(1, 1, 8'h00, 0, 16'hFFFF, 32'hFFFF_FFFF, 32'hFE00_FE00, 8'h00, 1);
    step(1, 0, 8'h00, 0, 16'hFFFF, 32'h0001_FFFF, 32'h0000_0000, 8'h00, 1);
    // Token chain: none of these may touch the shadow (0xFFFF).
    step(1, 0, 8'h83, 0, 16'h0005, 32'h0000_0000, 32'h0004_FFFB, 8'h82, 1);
    step(1, 0, 8'h81, 0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h80, 1);
    step(1, 0, 8'h05, 0, 16'h0006, 32'h0000_0000, 32'h0005_FFFA, 8'h00, 1);
    step(0, 0, 8'h80, 0, 16'h0007, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(0, 0, 8'h00, 1, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(1, 0, 8'h00, 0, 16'h0002, 32'h0000_0000, 32'h0001_FFFE, 8'h00, 1);
    // Double buffer: active 2, shadow 7, then swap with capture of 9.
    step(1, 0, 8'h80, 0, 16'h0002, 32'h0000_0000, 32'h0001_FFFE, 8'h00, 1);
    step(0, 0, 8'h00, 1, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(1, 0, 8'h80, 0, 16'h0007, 32'h0000_0000, 32'h0000_000E, 8'h00, 1);
    step(1, 0, 8'h00, 0, 16'h0010, 32'h0000_0001, 32'h0000_0021, 8'h00, 1);
    step(1, 0, 8'h80, 1, 16'h0009, 32'h0000_0000, 32'h0000_0012, 8'h00, 1);
    step(1, 0, 8'h00, 0, 16'h0010, 32'h0000_0000, 32'h0000_0070, 8'h00, 1);
    step(0, 0, 8'h00, 1, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(1, 0, 8'h00, 0, 16'h0003, 32'h0000_0000, 32'h0000_001B, 8'h00, 1);
    step(0, 0, 8'h00, 0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(0, 0, 8'h00, 0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    // Reset with two beats in flight.
    step(1, 0, 8'h00, 0, 16'h0001, 32'h0000_0000, 32'h0000_0000, 8'h00, 0);
    step(1, 0, 8'h00, 0, 16'h0002, 32'h0000_0000, 32'h0000_0000, 8'h00, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0; swap = 1'b0; load_ctrl = '0; data = '0; sum_in = '0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || sum_out !== '0) begin
      n_fail++;
      $display("FAIL reset_midstream: got ov=%b sum=%h, required ov=0 sum=00000000", out_valid,
               sum_out);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    exp_fwd = '0;
    exp_ldc = '0;
    step(0, 0, 8'h00, 0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(0, 0, 8'h00, 0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(0, 0, 8'h00, 0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    // Active weight was cleared by reset, so only sum_in survives.
    step(1, 0, 8'h00, 0, 16'h0003, 32'h0000_0004, 32'h0000_0004, 8'h00, 1);
    step(0, 0, 8'h00, 0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(0, 0, 8'h00, 0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);
    step(0, 0, 8'h00, 0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 8'h00, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d results still outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
